// File: rtl/game_event_ctrl.sv
// game_event_ctrl: power-pellet timer, ghost-eat score chain, score, lives and
// the IDLE/PLAY/DYING/OVER game state machine, advanced by the per-frame tick.
// Optional feature macro: EXTRA_LIFE_EN adds one bonus life the first time the
// score reaches 10000 in a game.
module game_event_ctrl #(
  parameter int unsigned POWER_TICKS = 480,
  parameter int unsigned DEATH_TICKS = 120,
  parameter int unsigned START_LIVES = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [3:0]  collide,
  input  logic        pellet_eaten,
  input  logic        power_eaten,
  input  logic        new_game,
  output logic        eat_time,
  output logic [2:0]  ghost_home,
  output logic        pac_respawn,
  output logic        freeze,
  output logic        game_over,
  output logic [1:0]  lives,
  output logic [15:0] score
);

  localparam int unsigned TW = 10;
  localparam int unsigned CW = 10;
  localparam int unsigned SW = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_DYING = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [CW-1:0] CHAIN_INIT = CW'(200);
  localparam logic [CW-1:0] CHAIN_MAX  = CW'(800);
  localparam logic [SW-1:0] BONUS_AT   = SW'(10000);

`ifdef EXTRA_LIFE_EN
  localparam bit EXTRA_LIFE = 1'b1;
`else
  localparam bit EXTRA_LIFE = 1'b0;
`endif

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] power_q, power_d;
  logic [TW-1:0] death_q, death_d;
  logic [CW-1:0] chain_q, chain_d;
  logic [SW-1:0] score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic          bonus_q, bonus_d;
  logic          eat_time_q, eat_time_d;
  logic [2:0]    ghost_home_q, ghost_home_d;
  logic          pac_respawn_q, pac_respawn_d;
  logic          freeze_q, freeze_d;
  logic          game_over_q, game_over_d;

  logic [2:0]    ghost_sel;
  logic          kill;
  logic [SW:0]   add;
  logic [SW:0]   sum;

  // Ghost priority: lowest collide index wins; a kill only counts with no ghost bit
  always_comb begin
    ghost_sel = 3'b000;
    if (collide[1])      ghost_sel = 3'b001;
    else if (collide[2]) ghost_sel = 3'b010;
    else if (collide[3]) ghost_sel = 3'b100;
    kill = collide[0] && (ghost_sel == 3'b000);
  end

  // Next-state, scoring and pulse generation
  always_comb begin
    state_d       = state_q;
    power_d       = power_q;
    death_d       = death_q;
    chain_d       = chain_q;
    score_d       = score_q;
    lives_d       = lives_q;
    bonus_d       = bonus_q;
    ghost_home_d  = 3'b000;
    pac_respawn_d = 1'b0;
    add           = '0;
    sum           = '0;

    if (new_game) begin
      state_d       = S_PLAY;
      score_d       = '0;
      lives_d       = 2'(START_LIVES);
      power_d       = '0;
      death_d       = '0;
      chain_d       = CHAIN_INIT;
      bonus_d       = 1'b0;
      ghost_home_d  = 3'b111;
      pac_respawn_d = 1'b1;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (pellet_eaten) add = add + (SW+1)'(10);
          if (frame_tick && kill) begin
            state_d = S_DYING;
            lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
            power_d = '0;
            death_d = TW'(DEATH_TICKS);
          end else begin
            if (frame_tick && (power_q != '0)) power_d = power_q - TW'(1);
            if (frame_tick && (ghost_sel != 3'b000)) begin
              ghost_home_d = ghost_sel;
              add          = add + (SW+1)'(chain_q);
              chain_d      = (chain_q >= CW'(400)) ? CHAIN_MAX : CW'(chain_q << 1);
            end
            // A power pellet reloads the timer and restarts the chain
            if (power_eaten) begin
              add     = add + (SW+1)'(50);
              power_d = TW'(POWER_TICKS);
              chain_d = CHAIN_INIT;
            end
          end
          sum     = (SW+1)'(score_q) + add;
          score_d = sum[SW] ? {SW{1'b1}} : sum[SW-1:0];
          if (EXTRA_LIFE && !bonus_q && (score_q < BONUS_AT) && (score_d >= BONUS_AT)) begin
            bonus_d = 1'b1;
            if (lives_d != 2'd3) lives_d = lives_d + 2'd1;
          end
        end
        S_DYING: begin
          if (frame_tick) begin
            if (death_q <= TW'(1)) begin
              death_d = '0;
              if (lives_q == 2'd0) begin
                state_d = S_OVER;
              end else begin
                state_d       = S_PLAY;
                ghost_home_d  = 3'b111;
                pac_respawn_d = 1'b1;
              end
            end else begin
              death_d = death_q - TW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    eat_time_d  = (state_d == S_PLAY) && (power_d != '0);
    freeze_d    = (state_d != S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  // State and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      power_q       <= '0;
      death_q       <= '0;
      chain_q       <= CHAIN_INIT;
      score_q       <= '0;
      lives_q       <= 2'(START_LIVES);
      bonus_q       <= 1'b0;
      eat_time_q    <= 1'b0;
      ghost_home_q  <= 3'b000;
      pac_respawn_q <= 1'b0;
      freeze_q      <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      power_q       <= power_d;
      death_q       <= death_d;
      chain_q       <= chain_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      bonus_q       <= bonus_d;
      eat_time_q    <= eat_time_d;
      ghost_home_q  <= ghost_home_d;
      pac_respawn_q <= pac_respawn_d;
      freeze_q      <= freeze_d;
      game_over_q   <= game_over_d;
    end
  end

  assign eat_time    = eat_time_q;
  assign ghost_home  = ghost_home_q;
  assign pac_respawn = pac_respawn_q;
  assign freeze      = freeze_q;
  assign game_over   = game_over_q;
  assign lives       = lives_q;
  assign score       = score_q;

endmodule

// File: doc/game_event_ctrl.md
# game_event_ctrl

Game-event controller on the receiving end of the collision detector: consumes its 4-bit `collide` vector and drives the `eat_time` signal that the detector uses to decide between "ghost eaten" and "Pac-Man killed". Owns the power-pellet timer, the ghost-eat score chain, score, lives, and the play/death/game-over state machine. Sits between the collision detector and the sprite movement/respawn logic, clocked on the system clock and advanced by the per-frame tick.

## Interface
- `POWER_TICKS`, 480: frames `eat_time` stays high after a power pellet (≤1023).
- `DEATH_TICKS`, 120: frames of death freeze (≤1023).
- `START_LIVES`, 3: lives loaded at game start (1–3).
- `Clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `collide`  in  4  from collision detector: [3] clyde eaten, [2] stinky eaten, [1] tinky eaten, [0] Pac-Man killed; at most one bit set.
- `pellet_eaten`  in  1  one-cycle pulse, normal pellet.
- `power_eaten`  in  1  one-cycle pulse, power pellet.
- `new_game`  in  1  one-cycle pulse, start/restart.
- `eat_time`  out  1  power mode active (registered).
- `ghost_home`  out  3  one-cycle respawn pulse: [2] clyde, [1] stinky, [0] tinky.
- `pac_respawn`  out  1  one-cycle Pac-Man respawn pulse.
- `freeze`  out  1  halt all sprite movement.
- `game_over`  out  1  high in OVER.
- `lives`  out  2  remaining lives.
- `score`  out  16  binary score, saturating.

## Operation
- States: IDLE (reset), PLAY, DYING, OVER. `freeze`=1 in IDLE, DYING, OVER.
- `new_game` highest priority, any state: → PLAY, score←0, lives←START_LIVES, power timer←0, chain←200, pulse `ghost_home`=3'b111 and `pac_respawn`.
- PLAY, any cycle: `pellet_eaten` adds 10; `power_eaten` adds 50, loads power timer with POWER_TICKS, resets chain to 200 (reload if already active).
- PLAY, `frame_tick` cycle only: power timer decrements if nonzero; `collide[3:1]` nonzero → pulse matching `ghost_home` bit, add chain value, chain doubles (200→400→800, holds at 800).
- PLAY, `frame_tick` with `collide`=4'b0001 → DYING: lives−1, power timer←0, death timer←DEATH_TICKS. Same-cycle `power_eaten` ignored; same-cycle `pellet_eaten` still scored.
- DYING: death timer decrements per `frame_tick`; on reaching 0: lives=0 → OVER; else → PLAY with `pac_respawn` and `ghost_home`=3'b111 pulses.
- OVER and IDLE: ignore all inputs except `new_game`.
- `eat_time` = (power timer ≠ 0) registered; always 0 outside PLAY.
- Score: all same-cycle contributions summed in 17 bits, saturate at 16'hFFFF.
- `collide` with multiple bits set: lowest-index ghost bit among [3:1] wins; [0] ignored if any ghost bit set.

## Timing
- Reset: state IDLE, score 0, lives START_LIVES, `eat_time` 0, `ghost_home` 0, `pac_respawn` 0, `freeze` 1, `game_over` 0, timers 0, chain 200.
- All outputs registered; every effect visible the cycle after the sampling edge.
- `eat_time` rises 1 cycle after `power_eaten`; falls 1 cycle after the POWER_TICKS-th subsequent `frame_tick`.
- Death: DYING entered 1 cycle after the killing `frame_tick`; PLAY re-entered 1 cycle after the DEATH_TICKS-th `frame_tick`.
- Pulse outputs exactly one cycle wide; never repeat without a new trigger.
- `Reset` mid-operation: immediate return to reset values, no pulses emitted.

## Configuration
- `EXTRA_LIFE_EN` defined: first time score goes from <10000 to ≥10000 within a game, lives+1 (saturate at 3) same cycle as score update; flag cleared by `new_game`. Not defined: no bonus life, lives only decrease.

## Test plan
- Reset, `new_game` → next cycle state PLAY, lives 3, score 0, `freeze` 0, `ghost_home` 3'b111 and `pac_respawn` pulse once.
- `power_eaten`, then 480 `frame_tick`s → score 50, `eat_time` 1 until 1 cycle after tick 480, then 0.
- Power active, collide 4'b1000, 4'b0100, 4'b0010 on three ticks → `ghost_home` pulses 100/010/001, score 50+200+400+800=1450.
- Power inactive, collide 4'b0001 on tick → DYING, lives 2, `freeze` 1; after 120 ticks → PLAY, respawn pulses; repeat to lives 0 → OVER, `game_over` 1.
- Score near 16'hFFF0, `pellet_eaten` ×3 → score 16'hFFFF; with `EXTRA_LIFE_EN`, crossing 10000 at lives 2 → lives 3 once only.
- Assert `Reset` during DYING with 50 ticks left → all outputs at reset values next edge, no `pac_respawn`.
